// File: rtl/int_exec_issue_unit.sv
// Integer execute stage fed by the integer issue queue.
// Single-cycle ALU ops go straight to the CDB request register. MUL spends MUL_LAT-1
// cycles in EXEC. The result is held on the CDB port until the arbiter grants it.
module int_exec_issue_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issueque_ready,
    input  logic [3:0]        issue_opcode,
    input  logic [TAG_W-1:0]  issue_rd_tag,
    input  logic [DATA_W-1:0] issue_rs1_data,
    input  logic [DATA_W-1:0] issue_rs2_data,
    output logic              issueblk_done,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic              CDB_valid,
    output logic [TAG_W-1:0]  CDB_tag,
    output logic [DATA_W-1:0] CDB_data,
    output logic [15:0]       busy_cycles
);

    localparam int unsigned SHW = $clog2(DATA_W);
    localparam int unsigned CW  = $clog2(MUL_LAT);
    localparam logic [CW-1:0] CntLoad = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpSll = 4'd5;
    localparam logic [3:0] OpSrl = 4'd6;
    localparam logic [3:0] OpSlt = 4'd7;
    localparam logic [3:0] OpMul = 4'd8;

    typedef enum logic [1:0] {StIdle, StExec, StWaitCdb} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [15:0]       busy_q, busy_d;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mul_res;
    logic              accept;
    logic              slt_bit;

    assign issueblk_done = (state_q == StIdle) || ((state_q == StWaitCdb) && cdb_grant);
    assign accept        = issueque_ready && issueblk_done;
    assign cdb_req       = (state_q == StWaitCdb);
    assign CDB_valid     = cdb_req && cdb_grant;
    assign CDB_tag       = tag_q;
    assign CDB_data      = data_q;
    assign busy_cycles   = busy_q;
    assign mul_res       = mul_a_q * mul_b_q;
    assign slt_bit       = $signed(issue_rs1_data) < $signed(issue_rs2_data);

    // Single-cycle ALU result for the entry currently offered by the queue
    always_comb begin
        alu_res = '0;
        case (issue_opcode)
            OpAdd:   alu_res = issue_rs1_data + issue_rs2_data;
            OpSub:   alu_res = issue_rs1_data - issue_rs2_data;
            OpAnd:   alu_res = issue_rs1_data & issue_rs2_data;
            OpOr:    alu_res = issue_rs1_data | issue_rs2_data;
            OpXor:   alu_res = issue_rs1_data ^ issue_rs2_data;
            OpSll:   alu_res = issue_rs1_data << issue_rs2_data[SHW-1:0];
            OpSrl:   alu_res = issue_rs1_data >> issue_rs2_data[SHW-1:0];
            OpSlt:   alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
            default: alu_res = '0;
        endcase
    end

    // Next-state logic: accept, MUL countdown, CDB hold/release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        data_d  = data_q;
        tag_d   = tag_q;
        case (state_q)
            StIdle, StWaitCdb: begin
                if (state_q == StWaitCdb && cdb_grant) begin
                    state_d = StIdle;
                end
                // A granted WAIT_CDB may take a new op in the same cycle (no bubble)
                if (accept) begin
                    tag_d = issue_rd_tag;
                    if (issue_opcode == OpMul) begin
                        state_d = StExec;
                        cnt_d   = CntLoad;
                        mul_a_d = issue_rs1_data;
                        mul_b_d = issue_rs2_data;
                    end else begin
                        state_d = StWaitCdb;
                        data_d  = alu_res;
                    end
                end
            end
            StExec: begin
                cnt_d = cnt_q - CntOne;
                // Counter reaching zero registers the product
                if (cnt_q == CntOne) begin
                    state_d = StWaitCdb;
                    data_d  = mul_res;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = busy_q;
        if (state_q != StIdle && busy_q != 16'hFFFF) begin
            busy_d = busy_q + 16'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

endmodule
